// File: rtl/punc_controller.sv
// Control FSM for the PUnC LC3 processor: sequences fetch, decode and up to
// three execute cycles, driving every datapath control input from state and IR.
module punc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    output logic        mem_wr_en,
    output logic [2:0]  mem_r_addr_sel,
    output logic        state2_sti,
    output logic        str,
    output logic [2:0]  rf_wr_addr,
    output logic [2:0]  rf_r_addr_0,
    output logic [2:0]  rf_r_addr_1,
    output logic        rf_wr_en,
    output logic [1:0]  rf_w_data_sel,
    output logic        ir_ld,
    output logic        jmp_ret_jsrr,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_up,
    output logic        add_const,
    output logic [1:0]  alu_sel,
    output logic        cc_en,
    output logic        n,
    output logic        z,
    output logic        p,
    output logic [10:0] const_imm,
    output logic [3:0]  sext_select,
    output logic        halted
);
    localparam logic [3:0] OP_BR   = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                           OP_ST   = 4'b0011, OP_JSR = 4'b0100, OP_AND = 4'b0101,
                           OP_LDR  = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001,
                           OP_LDI  = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                           OP_LEA  = 4'b1110, OP_TRAP = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC1, S_EXEC2, S_EXEC3, S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] opcode;

    assign opcode    = ir[15:12];
    assign const_imm = ir[10:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC1;
            S_EXEC1: begin
                case (opcode)
                    OP_LD, OP_LDR, OP_LDI, OP_STI: state_d = S_EXEC2;
                    OP_TRAP:                       state_d = S_HALT;
                    default:                       state_d = S_FETCH;
                endcase
            end
            S_EXEC2:  state_d = (opcode == OP_LDI) ? S_EXEC3 : S_FETCH;
            S_EXEC3:  state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_wr_en      = 1'b0;
        mem_r_addr_sel = 3'd0;
        state2_sti     = 1'b0;
        str            = 1'b0;
        rf_wr_addr     = 3'd0;
        rf_r_addr_0    = 3'd0;
        rf_r_addr_1    = 3'd0;
        rf_wr_en       = 1'b0;
        rf_w_data_sel  = 2'd0;
        ir_ld          = 1'b0;
        jmp_ret_jsrr   = 1'b0;
        pc_ld          = 1'b0;
        pc_clr         = 1'b0;
        pc_up          = 1'b0;
        add_const      = 1'b0;
        alu_sel        = 2'd0;
        cc_en          = 1'b0;
        n              = 1'b0;
        z              = 1'b0;
        p              = 1'b0;
        sext_select    = 4'b0000;
        halted         = 1'b0;

        // Reset overrides the state decode so no write can slip through mid-instruction.
        if (rst) begin
            pc_clr = 1'b1;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_ld = 1'b1;
                    pc_up = 1'b1;
                end
                S_EXEC1: begin
                    case (opcode)
                        OP_ADD, OP_AND: begin
                            rf_r_addr_0 = ir[8:6];
                            rf_r_addr_1 = ir[2:0];
                            add_const   = ir[5];
                            sext_select = 4'b1000;
                            alu_sel     = (opcode == OP_ADD) ? 2'd1 : 2'd2;
                            rf_wr_addr  = ir[11:9];
                            rf_wr_en    = 1'b1;
                            cc_en       = 1'b1;
                        end
                        OP_NOT: begin
                            rf_r_addr_0 = ir[8:6];
                            alu_sel     = 2'd3;
                            rf_wr_addr  = ir[11:9];
                            rf_wr_en    = 1'b1;
                            cc_en       = 1'b1;
                        end
                        OP_BR: begin
                            {n, z, p}   = ir[11:9];
                            sext_select = 4'b0010;
                        end
                        OP_JMP: begin
                            rf_r_addr_0  = ir[8:6];
                            jmp_ret_jsrr = 1'b1;
                            pc_ld        = 1'b1;
                        end
                        OP_JSR: begin
                            rf_wr_addr    = 3'd7;
                            rf_w_data_sel = 2'd1;
                            rf_wr_en      = 1'b1;
                            sext_select   = 4'b0001;
                            pc_ld         = 1'b1;
                            // JSRR reads the base before R7 is overwritten at the edge.
                            if (!ir[11]) begin
                                rf_r_addr_0  = ir[8:6];
                                jmp_ret_jsrr = 1'b1;
                            end
                        end
                        OP_LD: begin
                            mem_r_addr_sel = 3'd1;
                            sext_select    = 4'b0010;
                            rf_w_data_sel  = 2'd2;
                            rf_wr_addr     = ir[11:9];
                            rf_wr_en       = 1'b1;
                        end
                        OP_LDR: begin
                            rf_r_addr_0    = ir[8:6];
                            add_const      = 1'b1;
                            sext_select    = 4'b0100;
                            alu_sel        = 2'd1;
                            mem_r_addr_sel = 3'd4;
                            rf_w_data_sel  = 2'd2;
                            rf_wr_addr     = ir[11:9];
                            rf_wr_en       = 1'b1;
                        end
                        OP_LDI, OP_STI: begin
                            mem_r_addr_sel = 3'd1;
                            sext_select    = 4'b0010;
                        end
                        OP_LEA: begin
                            rf_w_data_sel = 2'd3;
                            sext_select   = 4'b0010;
                            rf_wr_addr    = ir[11:9];
                            rf_wr_en      = 1'b1;
                        end
                        OP_ST: begin
                            rf_r_addr_0 = ir[11:9];
                            sext_select = 4'b0010;
                            mem_wr_en   = 1'b1;
                        end
                        OP_STR: begin
                            rf_r_addr_0 = ir[8:6];
                            rf_r_addr_1 = ir[11:9];
                            add_const   = 1'b1;
                            sext_select = 4'b0100;
                            alu_sel     = 2'd1;
                            str         = 1'b1;
                            mem_wr_en   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EXEC2: begin
                    case (opcode)
                        OP_LDI: begin
                            mem_r_addr_sel = 3'd2;
                            rf_w_data_sel  = 2'd2;
                            rf_wr_addr     = ir[11:9];
                            rf_wr_en       = 1'b1;
                        end
                        OP_STI: begin
                            state2_sti  = 1'b1;
                            mem_wr_en   = 1'b1;
                            rf_r_addr_0 = ir[11:9];
                        end
                        default: begin
                            rf_r_addr_0 = ir[11:9];
                            cc_en       = 1'b1;
                        end
                    endcase
                end
                S_EXEC3: begin
                    rf_r_addr_0 = ir[11:9];
                    cc_en       = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/punc_controller.md
# punc_controller

Control FSM for the PUnC LC3 processor. It is the counterpart of the PUnC datapath: it consumes the instruction register word and drives every datapath control input, sequencing fetch, decode and multi-cycle execute for the LC3 instruction set. Outputs are combinational from the current state and `ir`. The datapath is assumed to read memory combinationally, write memory and the register file on `clk`, and latch the memory read data into its indirect register on every edge.

## Interface
Parameters: none.

- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `ir`  in  16  instruction register from the datapath
- `mem_wr_en`  out  1  memory write
- `mem_r_addr_sel`  out  3  memory read address: 0 pc, 1 pc+sext, 2 indirect latch, 3 mem data, 4 alu result
- `state2_sti`  out  1  memory write address from the indirect latch (else pc+sext)
- `str`  out  1  STR mode: write data is `rf_r_data_1` and the pc-adder output becomes the ALU result
- `rf_wr_addr`, `rf_r_addr_0`, `rf_r_addr_1`  out  3 each  register file addresses
- `rf_wr_en`  out  1  register file write
- `rf_w_data_sel`  out  2  register write data: 0 alu, 1 pc, 2 mem data, 3 pc+sext
- `ir_ld`  out  1  load IR
- `jmp_ret_jsrr`  out  1  PC load source is the ALU (else pc+sext)
- `pc_ld`, `pc_clr`, `pc_up`  out  1 each  PC load / clear / increment
- `add_const`  out  1  ALU operand B is the sign-extended constant
- `alu_sel`  out  2  ALU function: 0 pass, 1 add, 2 and, 3 not
- `cc_en`  out  1  update N/Z/P from the ALU result
- `n`, `z`, `p`  out  1 each  branch mask
- `const_imm`  out  11  always `ir[10:0]`
- `sext_select`  out  4  sign-extension width: 1000 imm5, 0100 off6, 0010 off9, 0001 off11
- `halted`  out  1  high in HALT

## Operation
- States: FETCH, DECODE, EXEC1, EXEC2, EXEC3, HALT. Every output not listed for a state is 0.
- **FETCH:** `mem_r_addr_sel`=0, `ir_ld`=1, `pc_up`=1. Next state is DECODE.
- **DECODE:** no outputs asserted. Next state is EXEC1.
- **EXEC1**, by `ir[15:12]`:
  - **ADD 0001 / AND 0101:** `r0`=`ir[8:6]`, `r1`=`ir[2:0]`, `add_const`=`ir[5]`, `sext`=1000, `alu_sel`=1 (ADD) or 2 (AND), `wr_addr`=`ir[11:9]`, `rf_wr_en`, `w_sel`=0, `cc_en`.
  - **NOT 1001:** `r0`=`ir[8:6]`, `alu_sel`=3, write `ir[11:9]`, `cc_en`.
  - **BR 0000:** {n,z,p}=`ir[11:9]`, `sext`=0010. The datapath performs the conditional load. n/z/p must be 0 in every other state.
  - **JMP 1100:** `r0`=`ir[8:6]`, `alu_sel`=0, `jmp_ret_jsrr`, `pc_ld`.
  - **JSR 0100, `ir[11]`=1:** `wr_addr`=7, `w_sel`=1, `rf_wr_en`, `sext`=0001, `pc_ld`.
  - **JSRR 0100, `ir[11]`=0:** same as JSR, plus `r0`=`ir[8:6]`, `alu_sel`=0, `jmp_ret_jsrr`. R7 receives the pre-edge PC.
  - **LD 0010:** `mem_r_addr_sel`=1, `sext`=0010, `w_sel`=2, write `ir[11:9]`. Next state is EXEC2.
  - **LDR 0110:** `r0`=`ir[8:6]`, `add_const`, `sext`=0100, `alu_sel`=1, `mem_r_addr_sel`=4, `w_sel`=2, write `ir[11:9]`. Next state is EXEC2.
  - **LDI 1010 / STI 1011:** `mem_r_addr_sel`=1, `sext`=0010 (the indirect latch captures the pointer). Next state is EXEC2.
  - **LEA 1110:** `w_sel`=3, `sext`=0010, write `ir[11:9]`. No CC update.
  - **ST 0011:** `r0`=`ir[11:9]`, `alu_sel`=0, `sext`=0010, `mem_wr_en`.
  - **STR 0111:** `r0`=`ir[8:6]`, `r1`=`ir[11:9]`, `add_const`, `sext`=0100, `alu_sel`=1, `str`, `mem_wr_en`.
  - **TRAP 1111:** next state is HALT.
  - **1000 / 1101:** treated as NOP.
  - Any opcode not routed to EXEC2 or HALT returns to FETCH.
- **EXEC2:**
  - **LD / LDR:** CC update: `r0`=`ir[11:9]`, `alu_sel`=0, `cc_en`. Next state is FETCH.
  - **LDI:** `mem_r_addr_sel`=2, `w_sel`=2, write `ir[11:9]`. Next state is EXEC3.
  - **STI:** `state2_sti`, `mem_wr_en`, `r0`=`ir[11:9]`, `alu_sel`=0. Next state is FETCH.
- **EXEC3 (LDI only):** CC update as for LD. Next state is FETCH.
- **HALT:** `halted`=1. HALT is sticky until `rst`.

## Timing
- **Reset:** while `rst`=1, all outputs are 0 except `pc_clr`=1. The state is FETCH on the first cycle after `rst` deasserts.
- **Reset mid-instruction:** aborts the instruction. No write enable is asserted in the `rst` cycle.
- **Latency:** 3 cycles for ADD/AND/NOT/BR/JMP/JSR(R)/LEA/ST/STR/NOP; 4 for LD/LDR/STI; 5 for LDI.
- PC is incremented at the end of FETCH, so all PC-relative offsets apply to PC+1.
- **JSRR with base R7:** the read precedes the write, so the jump uses the old R7.

## Test plan
- **Reset:** `rst` high for 2 cycles -> `pc_clr`=1 and all enables 0. After release, FETCH: `ir_ld`=1, `pc_up`=1, `mem_r_addr_sel`=0.
- **ADD:** `ir`=16'h1261 -> EXEC1: `rf_r_addr_0`=1, `add_const`=1, `sext_select`=1000, `alu_sel`=1, `rf_wr_addr`=1, `rf_wr_en`=1, `cc_en`=1. FETCH on the next cycle.
- **LDI:** `ir`=16'hA402 -> EXEC1 `mem_r_addr_sel`=1; EXEC2 `mem_r_addr_sel`=2, `rf_wr_addr`=2, `rf_w_data_sel`=2, `rf_wr_en`=1; EXEC3 `rf_r_addr_0`=2, `cc_en`=1. 5 cycles total.
- **BR:** `ir`=16'h0A03 -> n=1, z=0, p=1 only in EXEC1; all three 0 in FETCH and DECODE.
- **STI:** `ir`=16'hB601 -> EXEC2: `mem_wr_en`=1, `state2_sti`=1, `rf_r_addr_0`=3, `alu_sel`=0.
- **TRAP:** `ir`=16'hF025 -> `halted`=1 and `ir_ld`=0 held for 20 cycles. `rst` then returns the FSM to FETCH.
